// File: rtl/gpioemu.sv
// Bus-mapped N-th prime engine: trial division by a table of previously found primes,
// one divisor per cycle, with a GPIO-style observation side port.
module gpioemu #(
  parameter int unsigned MAX_N       = 9000,
  parameter int unsigned TABLE_DEPTH = 64
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp
);

  localparam int unsigned TW = $clog2(TABLE_DEPTH);
  localparam logic [15:0] ADDR_ARG    = 16'h00C8;
  localparam logic [15:0] ADDR_STATUS = 16'h00D0;
  localparam logic [15:0] ADDR_RESULT = 16'h00D8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_TEST,
    S_NEXT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] arg_q, arg_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] count_q, count_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] cand_q, cand_d;
  logic [31:0] sdata_out_q, sdata_out_d;
  logic [31:0] gpio_insp_q;

  logic [31:0] prime_tbl_q [TABLE_DEPTH];

  logic        wr_arg_c;
  logic        busy_c;
  logic [31:0] p_c;
  logic [63:0] sq_c;
  logic [31:0] rem_c;
  logic        is_prime_c;
  logic        tbl_we_c;
  logic [31:0] status_c;
  logic [31:0] rdata_c;

  assign wr_arg_c = swr && (saddress == ADDR_ARG);
  assign busy_c   = (state_q == S_INIT) || (state_q == S_TEST) || (state_q == S_NEXT);
  assign status_c = {29'd0, error_q, done_q, busy_c};

  // Entry 0 is the constant 2; only odd primes are ever written to the table.
  assign p_c   = (idx_q[TW-1:0] == '0) ? 32'd2 : prime_tbl_q[idx_q[TW-1:0]];
  assign sq_c  = 64'(p_c) * 64'(p_c);
  assign rem_c = (p_c == 32'd0) ? cand_q : (cand_q % p_c);

  // Running past the table only happens beyond the supported range; treat it as prime.
  assign is_prime_c = (idx_q == count_q) || (idx_q >= 16'(TABLE_DEPTH)) ||
                      (sq_c > 64'(cand_q));

  always_comb begin
    rdata_c = 32'd0;
    case (saddress)
      ADDR_ARG:    rdata_c = arg_q;
      ADDR_STATUS: rdata_c = status_c;
      ADDR_RESULT: rdata_c = result_q;
      default:     rdata_c = 32'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    arg_d       = arg_q;
    result_d    = result_q;
    done_d      = done_q;
    error_d     = error_q;
    count_d     = count_q;
    idx_d       = idx_q;
    cand_d      = cand_q;
    tbl_we_c    = 1'b0;
    sdata_out_d = srd ? rdata_c : 32'd0;

    case (state_q)
      S_IDLE: ;
      S_INIT: begin
        if ((arg_q == 32'd0) || (arg_q > 32'(MAX_N))) begin
          result_d = 32'd0;
          error_d  = 1'b1;
          count_d  = 16'd0;
          state_d  = S_DONE;
        end else if (arg_q == 32'd1) begin
          result_d = 32'd2;
          count_d  = 16'd1;
          state_d  = S_DONE;
        end else begin
          count_d = 16'd1;
          cand_d  = 32'd3;
          idx_d   = 16'd1;
          state_d = S_TEST;
        end
      end
      S_TEST: begin
        if (is_prime_c) begin
          tbl_we_c = (count_q < 16'(TABLE_DEPTH));
          count_d  = count_q + 16'd1;
          if ((32'(count_q) + 32'd1) == arg_q) begin
            result_d = cand_q;
            state_d  = S_DONE;
          end else begin
            state_d = S_NEXT;
          end
        end else if (rem_c == 32'd0) begin
          state_d = S_NEXT;
        end else begin
          idx_d = idx_q + 16'd1;
        end
      end
      S_NEXT: begin
        cand_d  = cand_q + 32'd2;
        idx_d   = 16'd1;
        state_d = S_TEST;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An ARG write always wins, aborting any search in flight.
    if (wr_arg_c) begin
      arg_d    = sdata_in;
      result_d = 32'd0;
      done_d   = 1'b0;
      error_d  = 1'b0;
      tbl_we_c = 1'b0;
      state_d  = S_INIT;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      arg_q       <= 32'd0;
      result_q    <= 32'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      count_q     <= 16'd0;
      idx_q       <= 16'd0;
      cand_q      <= 32'd0;
      sdata_out_q <= 32'd0;
      gpio_insp_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      arg_q       <= arg_d;
      result_q    <= result_d;
      done_q      <= done_d;
      error_q     <= error_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      cand_q      <= cand_d;
      sdata_out_q <= sdata_out_d;
      gpio_insp_q <= gpio_in;
    end
  end

  // Divisor table holds no reset; entries are always written before they are read.
  always_ff @(posedge clk) begin
    if (tbl_we_c) begin
      prime_tbl_q[count_q[TW-1:0]] <= cand_q;
    end
  end

  assign sdata_out      = sdata_out_q;
  assign gpio_out       = 32'(count_q);
  assign gpio_in_s_insp = gpio_insp_q;

endmodule

// File: tb/tb_gpioemu.sv
// Scoreboarded bench for gpioemu: bus reads queue expected values from a plain
// N-th-prime model; a monitor compares sdata_out one cycle after each read strobe.
module tb_gpioemu;

  localparam int unsigned MAX_N = 9000;
  localparam logic [15:0] A_ARG = 16'h00C8;
  localparam logic [15:0] A_STS = 16'h00D0;
  localparam logic [15:0] A_RES = 16'h00D8;

  logic        clk;
  logic        n_reset;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in_s_insp;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_seen;

  logic [31:0] m_arg, m_res, m_sts;

  gpioemu #(.MAX_N(MAX_N), .TABLE_DEPTH(64)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .saddress       (saddress),
    .srd            (srd),
    .swr            (swr),
    .sdata_in       (sdata_in),
    .sdata_out      (sdata_out),
    .gpio_in        (gpio_in),
    .gpio_out       (gpio_out),
    .gpio_in_s_insp (gpio_in_s_insp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference: count primes by naive trial division over all integers.
  function automatic logic [31:0] nth_prime(input logic [31:0] n);
    int unsigned c, k;
    bit ip;
    if (n == 0 || n > MAX_N) return 32'd0;
    k = 0;
    c = 1;
    while (k < n) begin
      c++;
      ip = 1'b1;
      for (int unsigned d = 2; d * d <= c; d++) begin
        if (c % d == 0) begin
          ip = 1'b0;
          break;
        end
      end
      if (ip) k++;
    end
    return 32'(c);
  endfunction

  function automatic logic [31:0] model_val(input logic [15:0] a);
    if (a == A_ARG) return m_arg;
    if (a == A_STS) return m_sts;
    if (a == A_RES) return m_res;
    return 32'd0;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [31:0] d);
    if (a == A_ARG) begin
      m_arg = d;
      m_res = 32'd0;
      m_sts = 32'd1;
    end
  endtask

  // Called once the search is known to have had enough time to finish.
  task automatic model_complete();
    m_res = nth_prime(m_arg);
    m_sts = (m_arg == 0 || m_arg > MAX_N) ? 32'd6 : 32'd2;
  endtask

  task automatic model_reset();
    m_arg = 32'd0;
    m_res = 32'd0;
    m_sts = 32'd0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    saddress = a;
    sdata_in = d;
    swr      = 1'b1;
    @(negedge clk);
    swr = 1'b0;
    model_write(a, d);
  endtask

  task automatic bus_read(input logic [15:0] a, input string name);
    @(negedge clk);
    saddress = a;
    srd      = 1'b1;
    exp_q.push_back(model_val(a));
    name_q.push_back(name);
    @(negedge clk);
    srd = 1'b0;
  endtask

  // Simultaneous read and write: the read must see the pre-write contents.
  task automatic bus_wr_rd(input logic [15:0] a, input logic [31:0] d, input string name);
    @(negedge clk);
    saddress = a;
    sdata_in = d;
    swr      = 1'b1;
    srd      = 1'b1;
    exp_q.push_back(model_val(a));
    name_q.push_back(name);
    @(negedge clk);
    swr = 1'b0;
    srd = 1'b0;
    model_write(a, d);
  endtask

  task automatic settle(input int cycles);
    repeat (cycles) @(negedge clk);
    model_complete();
  endtask

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) rd_seen <= 1'b0;
    else          rd_seen <= srd;
  end

  // Monitor: sdata_out is valid on the cycle after a read strobe is sampled.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", 32'd1, 32'd0);
      end else begin
        check(name_q.pop_front(), sdata_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] n, d, g;
    logic [15:0] a;
    n_reset  = 1'b0;
    saddress = 16'd0;
    srd      = 1'b0;
    swr      = 1'b0;
    sdata_in = 32'd0;
    gpio_in  = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    n_reset = 1'b1;

    check("rst_sdata_out", sdata_out, 32'd0);
    check("rst_gpio_out", gpio_out, 32'd0);
    bus_read(A_STS, "rst_status");

    // Unmapped write is ignored.
    bus_write(16'h0010, 32'h12345678);
    bus_read(A_ARG, "unmapped_wr_arg");
    bus_read(A_RES, "unmapped_wr_result");
    bus_read(16'h0010, "unmapped_rd");
    @(negedge clk);
    check("idle_sdata_out_zero", sdata_out, 32'd0);

    bus_write(A_ARG, 32'd5);
    settle(200);
    bus_read(A_RES, "n5_result");
    bus_read(A_STS, "n5_status");

    bus_write(A_ARG, 32'd10);
    settle(200);
    bus_read(A_RES, "n10_result");

    bus_write(A_ARG, 32'd1);
    settle(5);
    bus_read(A_RES, "n1_result");
    bus_read(A_STS, "n1_status");

    bus_write(A_ARG, 32'd2);
    settle(200);
    bus_read(A_RES, "n2_result");

    bus_write(A_ARG, 32'd0);
    settle(10);
    bus_read(A_RES, "n0_result");
    bus_read(A_STS, "n0_status");

    bus_write(A_ARG, MAX_N + 1);
    settle(10);
    bus_read(A_STS, "nmax1_status");

    // Write and read ARG in the same cycle.
    bus_wr_rd(A_ARG, 32'd7, "wr_rd_arg_old");
    settle(200);
    bus_read(A_ARG, "wr_rd_arg_new");
    bus_read(A_RES, "n7_result");

    // Long search with busy observed early.
    bus_write(A_ARG, 32'd1000);
    bus_read(A_STS, "n1000_busy");
    settle(50000);
    bus_read(A_RES, "n1000_result");
    check("n1000_gpio_out", gpio_out, 32'd1000);
    bus_read(A_STS, "n1000_status");

    // Abort a long search with a short one.
    bus_write(A_ARG, 32'd1000);
    repeat (100) @(negedge clk);
    bus_write(A_ARG, 32'd3);
    settle(200);
    bus_read(A_RES, "abort_result");
    check("abort_gpio_out", gpio_out, 32'd3);

    // Randomized operations.
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(3, 0))
        0: begin
          n = 32'($urandom_range(30, 1));
          bus_write(A_ARG, n);
          settle(600);
          bus_read(A_RES, "rand_result");
          bus_read(A_STS, "rand_status");
        end
        1: begin
          n = 32'($urandom_range(32'hFFFF_FFFF, MAX_N + 1));
          bus_write(A_ARG, n);
          settle(10);
          bus_read(A_RES, "rand_err_result");
          bus_read(A_STS, "rand_err_status");
        end
        2: begin
          a = 16'($urandom());
          if (a == A_ARG) a = 16'h00C9;
          d = $urandom();
          bus_write(a, d);
          bus_read(A_ARG, "rand_other_wr_arg");
        end
        default: begin
          a = 16'($urandom());
          bus_read(a, "rand_addr_read");
        end
      endcase
    end

    // Inspection register follows gpio_in by one clock.
    @(negedge clk);
    gpio_in = 32'hA5A5A5A5;
    @(negedge clk);
    check("gpio_insp_a5", gpio_in_s_insp, 32'hA5A5A5A5);
    g = $urandom();
    gpio_in = g;
    @(negedge clk);
    check("gpio_insp_rand", gpio_in_s_insp, g);

    // Reset in the middle of a search.
    bus_write(A_ARG, 32'd1000);
    bus_read(A_ARG, "pre_reset_arg");
    repeat (300) @(negedge clk);
    #2;
    n_reset = 1'b0;
    #1;
    check("midrst_sdata_out", sdata_out, 32'd0);
    check("midrst_gpio_out", gpio_out, 32'd0);
    check("midrst_gpio_insp", gpio_in_s_insp, 32'd0);
    model_reset();
    @(negedge clk);
    n_reset = 1'b1;
    repeat (5) @(negedge clk);
    bus_read(A_ARG, "post_reset_arg");
    bus_read(A_STS, "post_reset_status");
    bus_read(A_RES, "post_reset_result");
    check("post_reset_gpio_out", gpio_out, 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpioemu.md
Name: gpioemu

Overview:
- Bus-mapped peripheral that computes the N-th prime number, 1-based, so N=1 gives 2.
- The host writes N to the argument register; the block searches candidates with a hardware FSM using trial division by previously found primes.
- The host reads the result from the result register.
- Sits on the simple system bus (saddress/srd/swr/sdata) with a GPIO-style side interface for observation.

Parameters:
- MAX_N, 9000, largest supported N; any larger request finishes immediately with error.
- TABLE_DEPTH, 64, number of stored primes used as divisors (covers candidates up to 311^2).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- n_reset  in  1  asynchronous active-low reset.
- saddress  in  16  bus register address.
- srd  in  1  bus read strobe.
- swr  in  1  bus write strobe.
- sdata_in  in  32  bus write data.
- sdata_out  out  32  bus read data (registered).
- gpio_in  in  32  general input.
- gpio_out  out  32  progress output: count of primes found so far in the current search.
- gpio_in_s_insp  out  32  gpio_in registered once on clk (inspection copy).

Behaviour:
- Reset (n_reset=0, asynchronous):
  - all outputs and registers go to 0; FSM goes to IDLE.
  - prime table entry 0 = 2, remainder don't-care.
- Register map:
  - 0x00C8 ARG, R/W, N.
  - 0x00D0 STATUS, R: bit0 busy, bit1 done, bit2 error; other bits 0.
  - 0x00D8 RESULT, R.
  - Other addresses: writes ignored, reads return 0.
- Write:
  - on a rising edge with swr=1 and saddress=0x00C8: ARG<=sdata_in, RESULT<=0, done<=0, error<=0, FSM->INIT.
  - A write while busy aborts and restarts the search.
  - swr to any other address has no effect.
- Read:
  - on a rising edge with srd=1: sdata_out<=selected register; valid one cycle after srd asserts.
  - On an edge with srd=0: sdata_out<=0.
  - srd and swr together: the write takes effect, and the read returns the pre-write value.
- FSM states: IDLE, INIT, TEST, NEXT, DONE.
- INIT:
  - N=0 or N>MAX_N: RESULT=0, error=1 -> DONE.
  - N=1: RESULT=2 -> DONE.
  - Otherwise: count=1, cand=3, idx=1 -> TEST.
- TEST, one divisor per cycle, with p=table[idx]:
  - if idx==count or p*p>cand: cand is prime. Store it in table[count] if count<TABLE_DEPTH, count++. If count+1==N: RESULT=cand -> DONE. Else -> NEXT.
  - else if cand mod p==0 -> NEXT (composite).
  - else idx++.
- NEXT: cand+=2, idx=1 -> TEST.
- DONE:
  - busy=0, done=1; RESULT holds until the next ARG write or reset.
  - Returns to IDLE.
- Arithmetic widths: 32-bit candidate, 64-bit square compare, 16-bit count/idx.
- Busy is 1 in INIT/TEST/NEXT.
- gpio_out = count, zero-extended.
- Latency budgets from the ARG write:
  - N<=10: done within 200 cycles.
  - N=1000: done within 50,000 cycles.
- Reset mid-search: search abandoned, all registers return to reset values.

Test Plan:
- Reset, write 0x12345678 to 0x0010, then read 0x00C8 and 0x00D8 -> both 0; ARG unchanged.
- Write N=5 to 0x00C8, wait 200 cycles, read 0x00D8 -> 11; read 0x00D0 -> 0x2.
- Write N=10, wait 200 cycles -> RESULT 29. Write N=1 -> RESULT 2 within 5 cycles.
- Write N=1000, wait 50,000 cycles -> RESULT 7919; gpio_out=1000 at done.
- Write N=1000, then write N=3 after 100 cycles -> RESULT 5, no stale value.
- Write N=0 -> RESULT 0, STATUS 0x6. Drive gpio_in=0xA5A5A5A5 -> gpio_in_s_insp matches one cycle later. Assert n_reset low mid-search -> all outputs 0 immediately.
